// File: rtl/apb_loader_pkg.sv
// apb_loader_pkg: shared widths, bank address map and FSM states for the register-bank loader
package apb_loader_pkg;
    localparam int AMBA_WORD       = 16;
    localparam int AMBA_ADDR_DEPTH = 20;
    localparam int HDR_WORDS       = 9;
    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_WHITE    = 8'h01;
    localparam logic [7:0] ADDR_PSIZE    = 8'h02;
    localparam logic [7:0] ADDR_WSIZE    = 8'h03;
    localparam logic [7:0] ADDR_PIX_BASE = 8'h0A;
    typedef enum logic [2:0] {IDLE, CLR, HDR, CALC, PIX, GO, RD, RDW} state_t;
endpackage

// File: rtl/apb_loader.sv
// apb_loader: streams header and pixels into consecutive bank addresses, kicks CTRL, and serves idle read-backs
module apb_loader
    import apb_loader_pkg::*;
#(
    parameter int Amba_Word       = AMBA_WORD,
    parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [Amba_Word-1:0]     s_data,
    output logic                     s_ready,
    input  logic                     rd_req,
    input  logic [Amba_Addr_Depth:0] rd_addr,
    output logic [Amba_Word-1:0]     rd_data,
    output logic                     rd_valid,
    output logic                     write_en,
    output logic [Amba_Addr_Depth:0] addr,
    output logic [Amba_Word-1:0]     data_in,
    input  logic [Amba_Word-1:0]     data_out,
    output logic                     busy,
    output logic                     load_done,
    output logic                     err
);
    localparam int AW = Amba_Addr_Depth + 1;
    localparam int PW = 2 * Amba_Word + 1;
    // largest pixel count whose last address still fits the bank
    localparam logic [PW-1:0] PIX_MAX = PW'((64'd1 << AW) - 64'(ADDR_PIX_BASE));

    state_t               state_q, state_d;
    logic [3:0]           hdr_cnt_q, hdr_cnt_d;
    logic [AW-1:0]        pix_cnt_q, pix_cnt_d, pix_last_q, pix_last_d;
    logic [Amba_Word-1:0] np_q, np_d, nw_q, nw_d;
    logic                 s_ready_q, s_ready_d, rd_valid_q, rd_valid_d, write_en_q, write_en_d;
    logic                 busy_q, busy_d, load_done_q, load_done_d, err_q, err_d, go_q, go_d;
    logic [AW-1:0]        addr_q, addr_d, hdr_addr;
    logic [Amba_Word-1:0] rd_data_q, rd_data_d, data_in_q, data_in_d;
    logic [PW-1:0]        pix_total;
    logic                 accept;

    always_comb begin
        pix_total   = PW'(np_q) * PW'(np_q) + PW'(nw_q) * PW'(nw_q);
        accept      = s_valid && s_ready_q;
        hdr_addr    = AW'(ADDR_WHITE) + AW'(hdr_cnt_q);
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        pix_last_d  = pix_last_q;
        np_d        = np_q;
        nw_d        = nw_q;
        write_en_d  = 1'b0;
        addr_d      = addr_q;
        data_in_d   = data_in_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_d       = err_q;
        go_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = RD;
                    addr_d  = rd_addr;
                end else if (s_valid) begin
                    state_d   = CLR;
                    err_d     = 1'b0;
                    hdr_cnt_d = '0;
                    pix_cnt_d = '0;
                end
            end
            CLR: begin
                write_en_d = 1'b1;
                addr_d     = AW'(ADDR_CTRL);
                data_in_d  = '0;
                state_d    = HDR;
            end
            HDR: if (accept) begin
                write_en_d = 1'b1;
                addr_d     = hdr_addr;
                data_in_d  = s_data;
                np_d       = (hdr_addr == AW'(ADDR_PSIZE)) ? s_data : np_q;
                nw_d       = (hdr_addr == AW'(ADDR_WSIZE)) ? s_data : nw_q;
                hdr_cnt_d  = hdr_cnt_q + 4'd1;
                state_d    = (hdr_cnt_q == 4'(HDR_WORDS - 1)) ? CALC : HDR;
            end
            CALC: begin
                pix_last_d = AW'(pix_total - PW'(1));
                err_d      = err_q | (pix_total > PIX_MAX);
                state_d    = (pix_total > PIX_MAX) ? IDLE : (pix_total == '0) ? GO : PIX;
            end
            PIX: if (accept) begin
                write_en_d = 1'b1;
                addr_d     = AW'(ADDR_PIX_BASE) + pix_cnt_q;
                data_in_d  = s_data;
                pix_cnt_d  = pix_cnt_q + AW'(1);
                state_d    = (pix_cnt_q == pix_last_q) ? GO : PIX;
            end
            GO: begin
                write_en_d = 1'b1;
                addr_d     = AW'(ADDR_CTRL);
                data_in_d  = Amba_Word'(1);
                go_d       = 1'b1;
                state_d    = IDLE;
            end
            RD: state_d = RDW;
            RDW: begin
                rd_data_d  = data_out;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        s_ready_d   = (state_d == HDR) || (state_d == PIX);
        busy_d      = (state_d == CLR) || (state_d == HDR) || (state_d == CALC) || (state_d == PIX) || (state_d == GO);
        load_done_d = go_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            pix_last_q  <= '0;
            np_q        <= '0;
            nw_q        <= '0;
            s_ready_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            write_en_q  <= 1'b0;
            addr_q      <= '0;
            data_in_q   <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            go_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_last_q  <= pix_last_d;
            np_q        <= np_d;
            nw_q        <= nw_d;
            s_ready_q   <= s_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            write_en_q  <= write_en_d;
            addr_q      <= addr_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            go_q        <= go_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign write_en  = write_en_q;
    assign addr      = addr_q;
    assign data_in   = data_in_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_apb_loader.sv
// tb_apb_loader: random and directed loads checked against a map-based model of the bank contents and load timing
module tb_apb_loader;
    import apb_loader_pkg::*;
    localparam int W  = AMBA_WORD;
    localparam int AW = AMBA_ADDR_DEPTH + 1;
    localparam longint ADDR_MAX = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, rd_req, rd_valid, write_en, busy, load_done, err;
    logic [W-1:0]  s_data, rd_data, data_in, data_out;
    logic [AW-1:0] rd_addr, addr;

    logic [W-1:0] bank [int];
    logic [W-1:0] exp_bank [int];
    int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = -1, done_cyc = -1, done_hi = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    apb_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .write_en(write_en), .addr(addr), .data_in(data_in), .data_out(data_out),
        .busy(busy), .load_done(load_done), .err(err)
    );

    // bank samples the loader on the falling edge
    always @(negedge clk) begin
        if (write_en) begin
            bank[int'(addr)] = data_in;
            wr_cnt++;
        end else
            data_out = bank.exists(int'(addr)) ? bank[int'(addr)] : '0;
        if (load_done) begin
            done_hi++;
            if (done_cyc < 0) done_cyc = cyc - 1;
        end
    end

    always @(posedge clk) begin
        if (s_valid && s_ready && acc_cyc < 0) acc_cyc = cyc;
        cyc++;
    end

    function automatic logic [W-1:0] bank_at(input int a);
        return bank.exists(a) ? bank[a] : '0;
    endfunction

    function automatic logic [W-1:0] exp_at(input int a);
        return exp_bank.exists(a) ? exp_bank[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input int stall);
        bit ok = 1'b0;
        s_valid = 1'b0;
        tick(stall);
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 40 && !ok; t++) begin
            ok = s_ready;
            tick();
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_load(input logic [W-1:0] np, input logic [W-1:0] nw, input int max_stall,
                            input int stall_idx, input int stall_len, input bit seq);
        logic [W-1:0] hdr [HDR_WORDS];
        logic [W-1:0] pix [$];
        longint pt;
        bit ovf;
        int stalls = 0, w0, st;
        pt  = longint'(np) * longint'(np) + longint'(nw) * longint'(nw);
        ovf = (9 + pt) > ADDR_MAX;
        foreach (hdr[i]) hdr[i] = W'($urandom);
        hdr[1] = np;
        hdr[2] = nw;
        if (!ovf) for (int j = 0; j < pt; j++) pix.push_back(seq ? W'(16'h11 + j) : W'($urandom));
        acc_cyc  = -1;
        done_cyc = -1;
        done_hi  = 0;
        w0       = wr_cnt;
        for (int i = 0; i < HDR_WORDS; i++) begin
            st = (i > 0 && max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            stalls += st;
            send(hdr[i], st);
        end
        foreach (pix[j]) begin
            st = (j == stall_idx) ? stall_len : (j > 0 && max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            stalls += st;
            send(pix[j], st);
        end
        s_valid = 1'b0;
        foreach (hdr[i]) exp_bank[1 + i] = hdr[i];
        foreach (pix[j]) exp_bank[10 + j] = pix[j];
        exp_bank[0] = ovf ? W'(0) : W'(1);
        for (int t = 0; t < 12 && done_cyc < 0; t++) tick();
        tick(3);
        chk("done_pulses", done_hi, ovf ? 0 : 1);
        if (!ovf) chk("done_latency", done_cyc - acc_cyc, 11 + pt + stalls);
        chk("err", err, ovf);
        chk("write_count", wr_cnt - w0, ovf ? 10 : 11 + pt);
        chk("idle_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        for (int a = 0; a <= (ovf ? 9 : 9 + int'(pt)); a++)
            chk($sformatf("bank[%0h]", a), bank_at(a), exp_at(a));
    endtask

    task automatic do_read(input int a, input bit with_stream);
        rd_req  = 1'b1;
        rd_addr = AW'(a);
        if (with_stream) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
        end
        tick(2);
        chk("rd_early", rd_valid, 0);
        tick();
        chk("rd_valid", rd_valid, 1);
        chk($sformatf("rd_data[%0h]", a), rd_data, exp_at(a));
        chk("rd_before_load", busy, 0);
        rd_req = 1'b0;
        tick();
        chk("rd_pulse", rd_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_write_en"}, write_en, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data_in"}, data_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic abort_in_pix();
        logic [W-1:0] hdr [HDR_WORDS];
        foreach (hdr[i]) hdr[i] = W'($urandom);
        hdr[1] = W'(1448);
        hdr[2] = W'(20);
        foreach (hdr[i]) send(hdr[i], 0);
        s_valid = 1'b0;
        tick();
        chk("big_ready", s_ready, 1);
        chk("big_err", err, 0);
        foreach (hdr[i]) exp_bank[1 + i] = hdr[i];
        exp_bank[0] = '0;
        for (int j = 0; j < 3; j++) begin
            exp_bank[10 + j] = W'($urandom);
            send(exp_bank[10 + j], 0);
        end
        s_valid = 1'b0;
        done_hi = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("abort");
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("abort_no_done", done_hi, 0);
        for (int a = 0; a <= 12; a++) chk($sformatf("abort_bank[%0h]", a), bank_at(a), exp_at(a));
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; rd_req = 1'b0; rd_addr = '0; data_out = '0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);
        run_load(2, 1, 0, -1, 0, 1);
        do_read(12, 1);
        run_load(2, 1, 0, 2, 3, 1);
        run_load(0, 0, 0, -1, 0, 0);
        run_load(16'hFFFF, 16'hFFFF, 0, -1, 0, 0);
        chk("ovf_err_sticky", err, 1);
        do_read(0, 0);
        run_load(1448, 21, 1, -1, 0, 0);
        repeat (8) begin
            run_load(W'($urandom_range(4, 0)), W'($urandom_range(4, 0)), 2, -1, 0, 0);
            do_read(int'($urandom_range(14, 0)), 0);
        end
        abort_in_pix();
        run_load(3, 2, 1, -1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
